// File: rtl/servo_pkg.sv
// servo_pkg: shared types, constants and helper functions for the servo PWM
// generator.
//   width_t    - 12-bit microsecond pulse width type
//   clog2()    - ceiling log2 usable in constant expressions
//   slew_step  - clamped step of a width toward a target
//   TPU, SPAN, PW - derived constants for the default configuration
//                   (50 MHz clock, 1000..2000 us, 8-bit position)
package servo_pkg;

  typedef logic [11:0] width_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_CLK_HZ = 50_000_000;
  localparam int DEF_MIN_US = 1000;
  localparam int DEF_MAX_US = 2000;
  localparam int DEF_POS_W  = 8;

  localparam int TPU  = DEF_CLK_HZ / 1_000_000;
  localparam int SPAN = DEF_MAX_US - DEF_MIN_US;
  localparam int PW   = DEF_POS_W + clog2(SPAN + 1);

  // Move cur toward tgt by at most lim microseconds.
  function automatic width_t slew_step(input width_t cur, input width_t tgt,
                                       input int lim);
    int d;
    d = int'(tgt) - int'(cur);
    if (d > lim)       d = lim;
    else if (d < -lim) d = -lim;
    return width_t'(int'(cur) + d);
  endfunction

endpackage

// File: rtl/servo_serial_div.sv
// servo_serial_div: serial restoring divider, one quotient bit per cycle.
//   clk, reset_n  - clock, asynchronous active-low reset
//   start         - begin a divide (ignored while busy)
//   dividend      - DVD_W-bit numerator, captured on start
//   divisor       - DVS_W-bit denominator, captured on start (must be nonzero)
//   busy          - divide in progress
//   done          - one-cycle pulse; quotient valid in that cycle
//   quotient      - DVD_W-bit result
// A divide takes DVD_W+1 cycles from the start edge to the done pulse.
module servo_serial_div
  import servo_pkg::*;
#(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int CW = clog2(DVD_W + 1);

  logic [DVD_W-1:0] quo;   // dividend shifts out the top, quotient bits in the bottom
  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [CW-1:0]    cnt;

  logic [DVS_W:0]   shifted, diff;
  logic [DVS_W-1:0] rem_nxt;
  logic             ge;
  logic             unused_diff_msb;

  assign shifted = {rem, quo[DVD_W-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign ge      = (shifted >= {1'b0, dvs});
  // Remainder stays below the divisor, so the dropped top bit is always zero.
  assign rem_nxt = ge ? diff[DVS_W-1:0] : shifted[DVS_W-1:0];
  assign unused_diff_msb = diff[DVS_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        quo  <= dividend;
        rem  <= '0;
        dvs  <= divisor;
        cnt  <= CW'(DVD_W);
        busy <= 1'b1;
      end else if (busy) begin
        if (cnt == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          rem <= rem_nxt;
          quo <= {quo[DVD_W-2:0], ge};
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: hobby-servo PWM generator, one instance per servo channel.
//   clk          - system clock
//   reset_n      - asynchronous active-low reset
//   pos_in       - commanded position (POS_W bits) from the PIO export
//   enable       - output enable, latched at frame boundaries only
//   pwm_out      - registered servo pulse
//   frame_strobe - one-cycle pulse at each frame start
//   width_us     - pulse width (us) applied in the current frame
// The position is captured at each frame boundary and converted to a width by
// a serial divider; the result is applied at the following boundary, so a
// write never shortens or stretches a pulse already in flight.
// Optional build macro SERVO_SLEW_EN: limit width change to SLEW_US per frame.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int PERIOD_US = 20000,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int POS_W     = 8,
  parameter int SLEW_US   = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [POS_W-1:0] pos_in,
  input  logic             enable,
  output logic             pwm_out,
  output logic             frame_strobe,
  output width_t           width_us
);

  localparam int CYC_US  = CLK_HZ / 1_000_000;
  localparam int SPAN_US = MAX_US - MIN_US;
  localparam int PROD_W  = POS_W + clog2(SPAN_US + 1);
  localparam int PS_W    = (CYC_US > 1) ? clog2(CYC_US) : 1;
  localparam int US_W    = clog2(PERIOD_US);

  // ---------------------------------------------------------------- checks
  generate
    if (CLK_HZ < 1_000_000 || (CLK_HZ % 1_000_000) != 0) begin : g_bad_clk
      $error("servo_pwm_gen: CLK_HZ must be a nonzero multiple of 1 MHz");
    end
    if (!(MIN_US < MAX_US && MAX_US < PERIOD_US)) begin : g_bad_range
      $error("servo_pwm_gen: need MIN_US < MAX_US < PERIOD_US");
    end
    if (MAX_US > 4095) begin : g_bad_width
      $error("servo_pwm_gen: MAX_US does not fit the 12-bit width");
    end
    if (!(PROD_W + 2 < PERIOD_US * CYC_US)) begin : g_bad_div
      $error("servo_pwm_gen: divider cannot finish within one frame");
    end
    if (SLEW_US < 1) begin : g_bad_slew
      $error("servo_pwm_gen: SLEW_US must be positive");
    end
  endgenerate

  // ---------------------------------------------------------------- timebase
  logic [PS_W-1:0] prescaler;
  logic [US_W-1:0] us_cnt;
  logic            tick;
  logic            boundary;

  assign tick     = (prescaler == PS_W'(CYC_US - 1));
  assign boundary = tick && (us_cnt == US_W'(PERIOD_US - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      us_cnt    <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) us_cnt <= boundary ? '0 : us_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------- width calc
  logic [PROD_W-1:0] dividend;
  logic [PROD_W-1:0] quotient;
  logic              div_busy;
  logic              div_done;
  width_t            div_result;

  // Constant multiply only; the divide by 2^POS_W-1 is done serially.
  assign dividend = PROD_W'(pos_in) * PROD_W'(SPAN_US);

  servo_serial_div #(
    .DVD_W (PROD_W),
    .DVS_W (POS_W)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (boundary && !div_busy),
    .dividend (dividend),
    .divisor  ({POS_W{1'b1}}),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      div_result <= width_t'(MIN_US);
    else if (div_done) div_result <= width_t'(MIN_US) + width_t'(quotient);
  end

  width_t next_width;

  always_comb begin
    next_width = div_result;
`ifdef SERVO_SLEW_EN
    next_width = slew_step(width_us, div_result, SLEW_US);
`endif
  end

  // ---------------------------------------------------------------- frame latch
  logic enable_lat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_strobe <= 1'b0;
      width_us     <= width_t'(MIN_US);
      enable_lat   <= 1'b0;
    end else begin
      frame_strobe <= boundary;
      if (boundary) begin
        width_us   <= next_width;
        enable_lat <= enable;
      end
    end
  end

  // ---------------------------------------------------------------- output
  // Registered from the frame state, so the pulse starts one clk after the
  // boundary and lasts exactly width_us * CYC_US cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_out <= 1'b0;
    else          pwm_out <= enable_lat && (32'(us_cnt) < 32'(width_us));
  end

endmodule
